muldiv_seq: RTL

//  Iterative multiply/divide sequencer for the multicycle MIPS core. It implements MULT, MULTU, DIV and DIVU

---
 rtl/muldiv_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Latency: start accepted in cycle 0 -> done pulse in cycle WIDTH+2, identical for every op.
// Backpressure: busy=1 while an operation runs; start/hiwrite/lowrite seen while busy are dropped.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             hiwrite,
   input  logic             lowrite,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state;
   logic               sign_a;     // dividend/multiplicand negative (signed ops only)
   logic               sign_b;     // divisor/multiplier negative (signed ops only)
   logic               is_div;
   logic               dz_pend;    // divisor was zero at accept; reported at done
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   a_mag;      // magnitude of srca (raw for unsigned ops)
   logic [WIDTH-1:0]   b_mag;      // magnitude of srcb (raw for unsigned ops)
   logic [WIDTH-1:0]   a_raw;      // untouched srca, returned in HI on divide-by-zero
   logic [2*WIDTH-1:0] acc;        // {partial product, remaining multiplier bits}
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;

   logic               accept;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // A new operation may only begin from an idle or just-finished sequencer.
   assign accept = start && (state == S_IDLE || state == S_DONE);

   // Operand magnitudes at accept; op[0] selects the signed variants.
   always_comb begin
      abs_a = (op[0] && srca[WIDTH-1]) ? -srca : srca;
      abs_b = (op[0] && srcb[WIDTH-1]) ? -srcb : srcb;
   end

   // One radix-2 shift-add step and one restoring-divide step.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
      div_shift = {rem, quo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_mag};
   end

   // Sign correction applied in FIX; unsigned ops have both sign flags clear.
   always_comb begin
      prod_fix = (sign_a ^ sign_b) ? -acc : acc;
      quo_fix  = (sign_a ^ sign_b) ? -quo : quo;
      rem_fix  = sign_a ? -rem : rem;
   end

   // Sequencer FSM with registered status outputs and HI/LO ownership.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         dz      <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         is_div  <= 1'b0;
         dz_pend <= 1'b0;
         cnt     <= '0;
         a_mag   <= '0;
         b_mag   <= '0;
         a_raw   <= '0;
         acc     <= '0;
         rem     <= '0;
         quo     <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (accept) begin
                  sign_a  <= op[0] & srca[WIDTH-1];
                  sign_b  <= op[0] & srcb[WIDTH-1];
                  is_div  <= op[1];
                  dz_pend <= op[1] && (srcb == '0);
                  dz      <= 1'b0;
                  a_mag   <= abs_a;
                  b_mag   <= abs_b;
                  a_raw   <= srca;
                  cnt     <= '0;
                  acc     <= {{WIDTH{1'b0}}, abs_b};
                  rem     <= '0;
                  quo     <= abs_a;
                  busy    <= 1'b1;
                  state   <= op[1] ? S_DIV : S_MUL;
               end else begin
                  // MTHI/MTLO only land when no operation is being started.
                  if (hiwrite) hi <= wd;
                  if (lowrite) lo <= wd;
                  state <= S_IDLE;
               end
            end
            S_MUL: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= S_FIX;
            end
            S_DIV: begin
               // Keep the difference when it is non-negative, otherwise restore.
               if (!div_diff[WIDTH]) begin
                  rem <= div_diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= div_shift[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= S_FIX;
            end
            S_FIX: begin
               if (!is_div) begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end else if (dz_pend) begin
                  // Divide-by-zero: defined result, no sign correction.
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end
               dz    <= dz_pend;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
